// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int BTN_DEC = 0;
  localparam int BTN_INC = 1;
  localparam int BTN_SET = 2;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

endpackage

// File: rtl/btn_debounce.sv
// One key: 2-flop synchronizer, level debouncer, and an arm flag that stays low
// after reset until the key has been seen released for a full debounce window.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic db_o,
  output logic arm_o
);

  localparam logic [31:0] DB_TC = 32'(DEBOUNCE_CYCLES);

  logic        sync1_q;
  logic        sync2_q;
  logic        lvl;
  logic        db_q, db_d;
  logic [31:0] cnt_q, cnt_d;
  logic        arm_q, arm_d;
  logic [31:0] rel_cnt_q, rel_cnt_d;

  assign lvl = ~sync2_q;

  always_comb begin
    db_d      = db_q;
    cnt_d     = cnt_q;
    arm_d     = arm_q;
    rel_cnt_d = rel_cnt_q;

    // Counter reaches DB_TC after DEBOUNCE_CYCLES differing samples; db follows on the next one.
    if (lvl == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_TC) begin
      db_d  = lvl;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    if (!arm_q) begin
      if (lvl) begin
        rel_cnt_d = '0;
      end else if (rel_cnt_q == DB_TC) begin
        arm_d     = 1'b1;
        rel_cnt_d = '0;
      end else begin
        rel_cnt_d = rel_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b0;
      cnt_q     <= '0;
      arm_q     <= 1'b0;
      rel_cnt_q <= '0;
    end else begin
      sync1_q   <= btn_n_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

  assign db_o  = db_q;
  assign arm_o = arm_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces dec/inc/settime keys and turns them into single-cycle action strobes.
// Auto-repeat on inc/dec is built only when BTN_AUTOREPEAT_EN is defined.
//
// state  | meaning
// IDLE   | key released (or not yet armed); waiting for debounced press
// HOLD   | pressed; press pulse issued, counting REPEAT_DELAY
// REPEAT | auto-repeating every REPEAT_RATE cycles
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_dec_n,
  input  logic       btn_inc_n,
  input  logic       btn_settime_n,
  output logic       pulse_dec,
  output logic       pulse_inc,
  output logic       pulse_settime,
  output logic [2:0] held
);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [31:0] RPT_DELAY_TC = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPT_RATE_TC  = 32'(REPEAT_RATE - 1);
`endif

  logic [2:0] btn_n;
  logic [2:0] db;
  logic [2:0] arm;
  logic [2:0] act;
  logic [1:0] other_act;
  logic [1:0] key_pulse;
  logic       set_prev_q;
  logic       set_pulse_q;

  assign btn_n[BTN_DEC] = btn_dec_n;
  assign btn_n[BTN_INC] = btn_inc_n;
  assign btn_n[BTN_SET] = btn_settime_n;

  for (genvar g = 0; g < 3; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk),
      .rst_i  (reset),
      .btn_n_i(btn_n[g]),
      .db_o   (db[g]),
      .arm_o  (arm[g])
    );
  end

  // A key held through reset stays inert until it has been released and re-armed.
  assign act  = db & arm;
  assign held = db;

  assign other_act[BTN_DEC] = act[BTN_INC];
  assign other_act[BTN_INC] = act[BTN_DEC];

  for (genvar g = 0; g < 2; g++) begin : g_key
    btn_state_e  state_q, state_d;
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic        lock_q, lock_d;
    logic        pulse_q, pulse_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= IDLE;
        rpt_cnt_q <= '0;
        lock_q    <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        lock_q    <= lock_d;
        pulse_q   <= pulse_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      lock_d    = lock_q;
      pulse_d   = 1'b0;

      if (!act[g]) begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
        lock_d    = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Pressing while the opposite key is active (or rising together) locks out this hold.
            state_d   = HOLD;
            rpt_cnt_d = '0;
            lock_d    = other_act[g];
            pulse_d   = ~other_act[g];
          end
          HOLD: begin
`ifdef BTN_AUTOREPEAT_EN
            if (rpt_cnt_q == RPT_DELAY_TC) begin
              state_d   = REPEAT;
              rpt_cnt_d = '0;
              pulse_d   = ~lock_q;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 32'd1;
            end
`else
            state_d = HOLD;
`endif
          end
          REPEAT: begin
`ifdef BTN_AUTOREPEAT_EN
            if (rpt_cnt_q == RPT_RATE_TC) begin
              rpt_cnt_d = '0;
              pulse_d   = ~lock_q;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 32'd1;
            end
`else
            state_d   = HOLD;
            rpt_cnt_d = '0;
`endif
          end
          default: begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
            lock_d    = 1'b0;
          end
        endcase
      end
    end

    assign key_pulse[g] = pulse_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      set_prev_q  <= 1'b0;
      set_pulse_q <= 1'b0;
    end else begin
      set_prev_q  <= act[BTN_SET];
      set_pulse_q <= act[BTN_SET] & ~set_prev_q;
    end
  end

  assign pulse_dec     = key_pulse[BTN_DEC];
  assign pulse_inc     = key_pulse[BTN_INC];
  assign pulse_settime = set_pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner; expectations follow BTN_AUTOREPEAT_EN when defined.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int NMAX = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_dec_n = 1'b1;
  logic       btn_inc_n = 1'b1;
  logic       btn_settime_n = 1'b1;
  logic       pulse_dec, pulse_inc, pulse_settime;
  logic [2:0] held;
  logic [2:0] pulses;

  int n_checks = 0;
  int n_fail   = 0;

  bit press_pat [3][NMAX];
  bit rst_pat   [NMAX];
  bit exp_pulse [3][NMAX];
  bit exp_held  [3][NMAX];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_dec_n    (btn_dec_n),
    .btn_inc_n    (btn_inc_n),
    .btn_settime_n(btn_settime_n),
    .pulse_dec    (pulse_dec),
    .pulse_inc    (pulse_inc),
    .pulse_settime(pulse_settime),
    .held         (held)
  );

  assign pulses = {pulse_settime, pulse_inc, pulse_dec};

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pats();
    for (int e = 0; e < NMAX; e++) begin
      rst_pat[e] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        press_pat[k][e] = 1'b0;
        exp_pulse[k][e] = 1'b0;
        exp_held[k][e]  = 1'b0;
      end
    end
  endtask

  task automatic press(input int k, input int lo, input int hi);
    for (int e = lo; e <= hi; e++) press_pat[k][e] = 1'b1;
  endtask

  task automatic held_r(input int k, input int lo, input int hi);
    for (int e = lo; e <= hi; e++) exp_held[k][e] = 1'b1;
  endtask

  task automatic pulse_at(input int k, input int e);
    exp_pulse[k][e] = 1'b1;
  endtask

  // Inputs for edge e are applied just after edge e-1; outputs sampled 1ns after edge e.
  task automatic run(input string tag, input int n);
    for (int e = 0; e < n; e++) begin
      btn_dec_n     = ~press_pat[BTN_DEC][e];
      btn_inc_n     = ~press_pat[BTN_INC][e];
      btn_settime_n = ~press_pat[BTN_SET][e];
      reset         = rst_pat[e];
      step();
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("%s pulse[%0d]@%0d", tag, k, e),
                 {31'b0, pulses[k[1:0]]}, {31'b0, exp_pulse[k][e]});
        check_eq($sformatf("%s held[%0d]@%0d", tag, k, e),
                 {31'b0, held[k[1:0]]}, {31'b0, exp_held[k][e]});
      end
    end
    btn_dec_n     = 1'b1;
    btn_inc_n     = 1'b1;
    btn_settime_n = 1'b1;
    reset         = 1'b0;
  endtask

  initial begin
    clear_pats();
    reset = 1'b1;
    repeat (3) step();
    check_eq("reset held", {29'b0, held}, 32'd0);
    check_eq("reset pulses", {29'b0, pulses}, 32'd0);
    reset = 1'b0;
    repeat (20) step();

    clear_pats();
    press(BTN_INC, 0, 9);
    held_r(BTN_INC, 6, 15);
    pulse_at(BTN_INC, 7);
    run("clean", 30);

    clear_pats();
    press(BTN_INC, 0, 59);
    held_r(BTN_INC, 6, 65);
    pulse_at(BTN_INC, 7);
`ifdef BTN_AUTOREPEAT_EN
    pulse_at(BTN_INC, 27);
    pulse_at(BTN_INC, 35);
    pulse_at(BTN_INC, 43);
    pulse_at(BTN_INC, 51);
    pulse_at(BTN_INC, 59);
`endif
    run("repeat", 80);

    clear_pats();
    for (int e = 0; e < 20; e++) if (((e / 2) % 2) == 0) press_pat[BTN_DEC][e] = 1'b1;
    press(BTN_DEC, 20, 39);
    held_r(BTN_DEC, 26, 45);
    pulse_at(BTN_DEC, 27);
    run("bounce", 60);

    clear_pats();
    press(BTN_DEC, 0, 19);
    press(BTN_INC, 10, 19);
    press(BTN_SET, 5, 14);
    held_r(BTN_DEC, 6, 25);
    held_r(BTN_INC, 16, 25);
    held_r(BTN_SET, 11, 20);
    pulse_at(BTN_DEC, 7);
    pulse_at(BTN_SET, 12);
    run("lockout", 40);

    clear_pats();
    press(BTN_DEC, 0, 9);
    press(BTN_INC, 0, 9);
    held_r(BTN_DEC, 6, 15);
    held_r(BTN_INC, 6, 15);
    run("simul", 30);

    clear_pats();
    press(BTN_SET, 0, 99);
    held_r(BTN_SET, 6, 105);
    pulse_at(BTN_SET, 7);
    run("settime", 120);

    clear_pats();
    press(BTN_INC, 0, 49);
    press(BTN_INC, 65, 79);
    rst_pat[30] = 1'b1;
    rst_pat[31] = 1'b1;
    held_r(BTN_INC, 6, 29);
    held_r(BTN_INC, 38, 55);
    held_r(BTN_INC, 71, 85);
    pulse_at(BTN_INC, 7);
`ifdef BTN_AUTOREPEAT_EN
    pulse_at(BTN_INC, 27);
`endif
    pulse_at(BTN_INC, 72);
    run("rstmid", 95);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
